inst_encoder_writer: RTL

Instruction encoder and program writer for the MIPS single-cycle CPU: the encode-side counterpart of the control decoder. Accepts symbolic instruction requests (kind plus register and immediate fields) over a valid/ready handshake, packs each into a 32-bit MIPS word, and writes the words sequentially into instruction memory. Used by the program-loading path to build instruction memory contents in hardware, as an alternative to a pre-generated `.coe`.

---
 rtl/inst_encoder_writer_if.sv | 41 ++++
 rtl/inst_encoder_writer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_writer_if.sv
// ---------------------------------------------------------------------------
// inst_encoder_writer_if
// Bundles the request handshake and the instruction-memory write port of the
// instruction encoder/writer.
//   slave  : view used by the encoder (consumes requests, drives memory port)
//   master : view used by the request producer / memory model / bench
// Signals:
//   in_valid, in_ready            request handshake
//   in_kind, in_rs, in_rt, in_rd  symbolic instruction fields
//   in_imm                        immediate ([15:0] I-type, [25:0] J-type)
//   mem_we, mem_addr, mem_wdata   one-cycle word write strobe, address, data
//   count, full, err              status: words written, capacity hit, sticky
//                                 illegal-kind flag
// ---------------------------------------------------------------------------
interface inst_encoder_writer_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/inst_encoder_writer.sv
// ---------------------------------------------------------------------------
// inst_encoder_writer
// Encodes symbolic MIPS instruction requests into 32-bit words and writes them
// sequentially into instruction memory, one word every two cycles.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   flush  synchronous program restart (index, count, full, err cleared)
//   bus    inst_encoder_writer_if.slave: request handshake + memory write port
// Parameters:
//   ADDR_W     instruction memory word-address width (capacity 2^ADDR_W)
//   BASE_ADDR  word address of the first write after reset/flush
// Configuration macro:
//   ENCODER_DELAY_SLOT_EN  when defined, every BEQ/J write is followed by a
//                          nop (32'h0) pad write at the next address, unless
//                          the branch itself filled the memory.
// ---------------------------------------------------------------------------
module inst_encoder_writer #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  inst_encoder_writer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] base_addr_c = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   cap_c       = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [3:0] k_add  = 4'd0;
  localparam logic [3:0] k_sub  = 4'd1;
  localparam logic [3:0] k_and  = 4'd2;
  localparam logic [3:0] k_or   = 4'd3;
  localparam logic [3:0] k_slt  = 4'd4;
  localparam logic [3:0] k_lw   = 4'd5;
  localparam logic [3:0] k_sw   = 4'd6;
  localparam logic [3:0] k_beq  = 4'd7;
  localparam logic [3:0] k_addi = 4'd8;
  localparam logic [3:0] k_andi = 4'd9;
  localparam logic [3:0] k_lui  = 4'd10;
  localparam logic [3:0] k_ori  = 4'd11;
  localparam logic [3:0] k_xori = 4'd12;
  localparam logic [3:0] k_j    = 4'd13;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_write = 2'd1,
`ifdef ENCODER_DELAY_SLOT_EN
    st_pad   = 2'd3,
`endif
    st_full  = 2'd2
  } state_t;

  // Packs one request into a MIPS word; bit 32 is set when the kind is legal.
  function automatic logic [32:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [25:0] imm
  );
    logic [32:0] res;
    case (kind)
      k_add:   res = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      k_sub:   res = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      k_and:   res = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      k_or:    res = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      k_slt:   res = {1'b1, 6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      k_lw:    res = {1'b1, 6'b100011, rs, rt, imm[15:0]};
      k_sw:    res = {1'b1, 6'b101011, rs, rt, imm[15:0]};
      k_beq:   res = {1'b1, 6'b000100, rs, rt, imm[15:0]};
      k_addi:  res = {1'b1, 6'b001000, rs, rt, imm[15:0]};
      k_andi:  res = {1'b1, 6'b001100, rs, rt, imm[15:0]};
      k_lui:   res = {1'b1, 6'b001111, 5'b00000, rt, imm[15:0]};
      k_ori:   res = {1'b1, 6'b001101, rs, rt, imm[15:0]};
      k_xori:  res = {1'b1, 6'b001110, rs, rt, imm[15:0]};
      k_j:     res = {1'b1, 6'b000010, imm};
      default: res = {1'b0, 32'h0000_0000};
    endcase
    return res;
  endfunction

  state_t            state_r, state_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic              full_r, full_s;
  logic              err_r, err_s;
  logic [32:0]       enc_s;
  logic [ADDR_W:0]   count_inc_s;
`ifdef ENCODER_DELAY_SLOT_EN
  logic              branch_r, branch_s;
`endif

  assign enc_s       = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
  assign count_inc_s = count_r + {{ADDR_W{1'b0}}, 1'b1};

  // Ready depends only on state and flush so a producer never sees it glitch on its own inputs.
  assign bus.in_ready  = (state_r == st_idle) && !flush;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.count     = count_r;
  assign bus.full      = full_r;
  assign bus.err       = err_r;

  // Next-state and next-output logic; flush overrides every state.
  always_comb begin
    state_s  = state_r;
    mem_we_s = 1'b0;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    count_s  = count_r;
    full_s   = full_r;
    err_s    = err_r;
`ifdef ENCODER_DELAY_SLOT_EN
    branch_s = branch_r;
`endif
    if (flush) begin
      state_s = st_idle;
      addr_s  = base_addr_c;
      count_s = {(ADDR_W+1){1'b0}};
      full_s  = 1'b0;
      err_s   = 1'b0;
`ifdef ENCODER_DELAY_SLOT_EN
      branch_s = 1'b0;
`endif
    end else begin
      case (state_r)
        st_idle: begin
          if (bus.in_valid && enc_s[32]) begin
            state_s  = st_write;
            mem_we_s = 1'b1;
            wdata_s  = enc_s[31:0];
`ifdef ENCODER_DELAY_SLOT_EN
            branch_s = (bus.in_kind == k_beq) || (bus.in_kind == k_j);
`endif
          end else if (bus.in_valid) begin
            // Illegal kind: consumed, flagged, nothing written.
            err_s = 1'b1;
          end else begin
            state_s = st_idle;
          end
        end
        st_write: begin
          count_s = count_inc_s;
          addr_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (count_inc_s == cap_c) begin
            // A branch that fills memory gets no pad.
            state_s = st_full;
            full_s  = 1'b1;
`ifdef ENCODER_DELAY_SLOT_EN
          end else if (branch_r) begin
            state_s  = st_pad;
            mem_we_s = 1'b1;
            wdata_s  = 32'h0000_0000;
`endif
          end else begin
            state_s = st_idle;
          end
        end
`ifdef ENCODER_DELAY_SLOT_EN
        st_pad: begin
          count_s  = count_inc_s;
          addr_s   = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          branch_s = 1'b0;
          if (count_inc_s == cap_c) begin
            state_s = st_full;
            full_s  = 1'b1;
          end else begin
            state_s = st_idle;
          end
        end
`endif
        st_full: begin
          state_s = st_full;
        end
        default: begin
          state_s = st_idle;
        end
      endcase
    end
  end

  // State and output registers; reset clears the write strobe asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= st_idle;
      mem_we_r <= 1'b0;
      addr_r   <= base_addr_c;
      wdata_r  <= 32'h0000_0000;
      count_r  <= {(ADDR_W+1){1'b0}};
      full_r   <= 1'b0;
      err_r    <= 1'b0;
`ifdef ENCODER_DELAY_SLOT_EN
      branch_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      mem_we_r <= mem_we_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      count_r  <= count_s;
      full_r   <= full_s;
      err_r    <= err_s;
`ifdef ENCODER_DELAY_SLOT_EN
      branch_r <= branch_s;
`endif
    end
  end

endmodule
